program_loader: RTL and testbench

- Byte-stream program loader. It is the writer side of the accumulator CPU's instruction-load interface: `we`, `instr_addr[3:0]` and `instr_in[11:0]`.
- It receives a framed program over an 8-bit valid/ready byte channel and checks its length and checksum.
- Each instruction is written into CPU instruction memory while the CPU is held in reset.
- The CPU is released to run from PC=0 only after a successful load.

---
 rtl/program_loader.sv | 155 +++++++++++++++
 tb/tb_program_loader.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Byte-stream program loader: parses a framed program, writes it into CPU
// instruction memory under reset, then releases the CPU from PC=0.
module program_loader #(
  parameter int          MEM_DEPTH = 10,
  parameter logic [7:0]  HEADER    = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        cpu_reset,
  output logic        we,
  output logic [3:0]  instr_addr,
  output logic [11:0] instr_in,
  output logic        loading,
  output logic        done,
  output logic        error,
  output logic [3:0]  loaded_count
);

  typedef enum logic [3:0] {
    IDLE,
    COUNT,
    OPC,
    OPR,
    WRITE,
    CHK,
    RELEASE,
    RUN,
    ERROR
  } state_t;

  state_t     state;
  logic [3:0] n_q;
  logic [3:0] opc_q;
  logic [7:0] checksum;

  logic       xfer;
  logic       is_hdr;
  logic       n_ok;
  logic [3:0] cnt_nxt;

  assign xfer    = byte_valid & byte_ready;
  assign is_hdr  = (byte_in == HEADER);
  assign n_ok    = (byte_in != 8'd0) &&
                   (byte_in <= 8'(MEM_DEPTH));
  assign cnt_nxt = loaded_count + 4'd1;

  // Handshake and status flags depend on the state register alone.
  always_comb begin
    byte_ready = 1'b1;
    loading    = 1'b0;
    unique case (1'b1)
      (state == WRITE),
      (state == RELEASE): byte_ready = 1'b0;
      default:            byte_ready = 1'b1;
    endcase
    unique case (state)
      COUNT, OPC, OPR,
      WRITE, CHK, RELEASE: loading = 1'b1;
      default:             loading = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cpu_reset    <= 1'b1;
      we           <= 1'b0;
      instr_addr   <= 4'd0;
      instr_in     <= 12'd0;
      done         <= 1'b0;
      error        <= 1'b0;
      loaded_count <= 4'd0;
      checksum     <= 8'd0;
      n_q          <= 4'd0;
      opc_q        <= 4'd0;
    end else begin
      we <= 1'b0;
      unique case (state)
        IDLE, RUN, ERROR: begin
          if (xfer && is_hdr) begin
            state        <= COUNT;
            cpu_reset    <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            loaded_count <= 4'd0;
            checksum     <= 8'd0;
          end
        end
        COUNT: begin
          if (xfer) begin
            if (n_ok) begin
              n_q      <= byte_in[3:0];
              checksum <= byte_in;
              state    <= OPC;
            end else begin
              state <= ERROR;
              error <= 1'b1;
            end
          end
        end
        OPC: begin
          if (xfer) begin
            if (byte_in[7:4] != 4'h0) begin
              state <= ERROR;
              error <= 1'b1;
            end else begin
              opc_q    <= byte_in[3:0];
              checksum <= checksum ^ byte_in;
              state    <= OPR;
            end
          end
        end
        OPR: begin
          // CPU leaves reset only while we=1, so it writes, never executes.
          if (xfer) begin
            checksum   <= checksum ^ byte_in;
            instr_in   <= {opc_q, byte_in};
            instr_addr <= loaded_count;
            we         <= 1'b1;
            cpu_reset  <= 1'b0;
            state      <= WRITE;
          end
        end
        WRITE: begin
          loaded_count <= cnt_nxt;
          cpu_reset    <= 1'b1;
          state        <= (cnt_nxt == n_q) ? CHK : OPC;
        end
        CHK: begin
          if (xfer) begin
            if (byte_in == checksum) begin
              state <= RELEASE;
            end else begin
              state <= ERROR;
              error <= 1'b1;
            end
          end
        end
        RELEASE: begin
          state     <= RUN;
          cpu_reset <= 1'b0;
          done      <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          cpu_reset <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: frame-level reference model checked every cycle,
// directed frames with literal expectations, and randomized frames.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  byte_in = 8'd0;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic        cpu_reset;
  logic        we;
  logic [3:0]  instr_addr;
  logic [11:0] instr_in;
  logic        loading;
  logic        done;
  logic        error;
  logic [3:0]  loaded_count;

  int checks = 0;
  int errors = 0;

  program_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .byte_in      (byte_in),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .cpu_reset    (cpu_reset),
    .we           (we),
    .instr_addr   (instr_addr),
    .instr_in     (instr_in),
    .loading      (loading),
    .done         (done),
    .error        (error),
    .loaded_count (loaded_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference model: position within the frame plus pending stall cycles.
  bit         m_frame = 0;
  bit         m_wr = 0;
  bit         m_rel = 0;
  bit         m_run = 0;
  bit         m_err = 0;
  int         m_p = 0;
  int         m_n = 0;
  int         m_cnt = 0;
  logic [7:0] m_sum = 8'd0;
  logic [3:0] m_opc = 4'd0;
  logic [3:0] m_addr = 4'd0;
  logic [11:0] m_instr = 12'd0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_frame = 0; m_wr = 0; m_rel = 0; m_run = 0; m_err = 0;
      m_p = 0; m_n = 0; m_cnt = 0; m_sum = 8'd0; m_opc = 4'd0;
      m_addr = 4'd0; m_instr = 12'd0;
    end else if (m_wr) begin
      m_wr = 0;
      m_cnt++;
    end else if (m_rel) begin
      m_rel = 0;
      m_frame = 0;
      m_run = 1;
    end else if (byte_valid) begin
      if (!m_frame) begin
        if (byte_in == 8'hA5) begin
          m_frame = 1; m_p = 0; m_run = 0; m_err = 0;
          m_cnt = 0; m_sum = 8'd0;
        end
      end else if (m_p == 0) begin
        if (byte_in >= 1 && byte_in <= 10) begin
          m_n = int'(byte_in); m_sum = byte_in; m_p = 1;
        end else begin
          m_frame = 0; m_err = 1;
        end
      end else if (m_p <= 2 * m_n) begin
        if (m_p % 2 == 1) begin
          if (byte_in[7:4] != 4'h0) begin
            m_frame = 0; m_err = 1;
          end else begin
            m_opc = byte_in[3:0]; m_sum ^= byte_in; m_p++;
          end
        end else begin
          m_sum ^= byte_in; m_p++;
          m_wr = 1;
          m_addr = 4'(m_cnt);
          m_instr = {m_opc, byte_in};
        end
      end else begin
        if (byte_in == m_sum) m_rel = 1;
        else begin
          m_frame = 0; m_err = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("byte_ready", 32'(byte_ready), 32'(!(m_wr || m_rel)));
      chk("we", 32'(we), 32'(m_wr));
      chk("cpu_reset", 32'(cpu_reset), 32'(!(m_wr || m_run)));
      chk("instr_addr", 32'(instr_addr), 32'(m_addr));
      chk("instr_in", 32'(instr_in), 32'(m_instr));
      chk("loading", 32'(loading), 32'(m_frame));
      chk("done", 32'(done), 32'(m_run));
      chk("error", 32'(error), 32'(m_err));
      chk("loaded_count", 32'(loaded_count), 32'(m_cnt));
    end
  end

  logic [15:0] wlog[$];

  always @(negedge clk) begin
    if (rst_n && we) begin
      wlog.push_back({instr_addr, instr_in});
      chk("ready_in_write", 32'(byte_ready), 32'd0);
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit rnd);
    bit acc = 0;
    int t = 0;
    while (!acc) begin
      @(negedge clk);
      byte_in = b;
      byte_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      acc = byte_valid && byte_ready;
      @(posedge clk);
      #1 byte_valid = 1'b0;
      t++;
      if (!acc && t > 200) begin
        chk("send_timeout", 32'd0, 32'd1);
        return;
      end
    end
  endtask

  task automatic send_frame(input logic [7:0] f[$], input bit rnd);
    foreach (f[i]) send_byte(f[i], rnd);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_vals(input string nm);
    chk({nm, "_crst"}, 32'(cpu_reset), 32'd1);
    chk({nm, "_we"}, 32'(we), 32'd0);
    chk({nm, "_addr"}, 32'(instr_addr), 32'd0);
    chk({nm, "_instr"}, 32'(instr_in), 32'd0);
    chk({nm, "_done"}, 32'(done), 32'd0);
    chk({nm, "_err"}, 32'(error), 32'd0);
    chk({nm, "_cnt"}, 32'(loaded_count), 32'd0);
    chk({nm, "_rdy"}, 32'(byte_ready), 32'd1);
    chk({nm, "_load"}, 32'(loading), 32'd0);
  endtask

  logic [7:0] fr[$];
  logic [7:0] good[$];
  logic [7:0] sum;
  logic [7:0] b;

  initial begin
    good = '{8'hA5, 8'h02, 8'h01, 8'h05, 8'h02, 8'h03, 8'h07};
    #12;
    check_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Good frame back-to-back
    wlog.delete();
    send_frame(good, 0);
    @(negedge clk);
    chk("release_crst", 32'(cpu_reset), 32'd1);
    @(negedge clk);
    chk("run_crst", 32'(cpu_reset), 32'd0);
    chk("run_done", 32'(done), 32'd1);
    chk("run_cnt", 32'(loaded_count), 32'd2);
    chk("wlog_size", 32'(wlog.size()), 32'd2);
    if (wlog.size() == 2) begin
      chk("write0", 32'(wlog[0]), 32'h0105);
      chk("write1", 32'(wlog[1]), 32'h1203);
    end

    // Stray byte in RUN
    send_byte(8'h33, 0);
    idle(2);
    chk("stray_done", 32'(done), 32'd1);
    chk("stray_crst", 32'(cpu_reset), 32'd0);

    // Bad checksum, then recovery
    fr = '{8'hA5, 8'h02, 8'h01, 8'h05, 8'h02, 8'h03, 8'h06};
    send_frame(fr, 0);
    idle(2);
    chk("badsum_err", 32'(error), 32'd1);
    chk("badsum_crst", 32'(cpu_reset), 32'd1);
    chk("badsum_done", 32'(done), 32'd0);
    send_frame(good, 0);
    idle(2);
    chk("recover_done", 32'(done), 32'd1);

    // Bad counts and bad opcode byte: no writes
    wlog.delete();
    fr = '{8'hA5, 8'h00};
    send_frame(fr, 0);
    idle(1);
    chk("cnt00_err", 32'(error), 32'd1);
    fr = '{8'hA5, 8'h0B};
    send_frame(fr, 0);
    idle(1);
    chk("cnt0b_err", 32'(error), 32'd1);
    fr = '{8'hA5, 8'h01, 8'h11};
    send_frame(fr, 0);
    idle(2);
    chk("opc11_err", 32'(error), 32'd1);
    chk("nowrite", 32'(wlog.size()), 32'd0);

    // Full 10-instruction frame with random valid gaps
    wlog.delete();
    fr = '{8'hA5, 8'h0A};
    sum = 8'h0A;
    for (int i = 0; i < 20; i++) begin
      b = (i % 2 == 0) ? {4'h0, 4'($urandom_range(0, 15))}
                       : 8'($urandom_range(0, 255));
      sum ^= b;
      fr.push_back(b);
    end
    fr.push_back(sum);
    send_frame(fr, 1);
    idle(3);
    chk("full_done", 32'(done), 32'd1);
    chk("full_cnt", 32'(loaded_count), 32'd10);
    chk("full_wlog", 32'(wlog.size()), 32'd10);
    foreach (wlog[i]) chk("full_addr", 32'(wlog[i][15:12]), 32'(i));

    // HEADER while running raises cpu_reset next cycle
    send_byte(8'hA5, 0);
    @(negedge clk);
    chk("hdr_run_crst", 32'(cpu_reset), 32'd1);
    chk("hdr_run_done", 32'(done), 32'd0);

    // Randomized frames, occasionally corrupted
    for (int k = 0; k < 12; k++) begin
      int n;
      n = $urandom_range(0, 11);
      fr = '{8'hA5, 8'(n)};
      sum = 8'(n);
      for (int i = 0; i < 2 * n; i++) begin
        if (i % 2 == 0 && $urandom_range(0, 11) != 0)
          b = {4'h0, 4'($urandom_range(0, 15))};
        else
          b = 8'($urandom_range(0, 255));
        sum ^= b;
        fr.push_back(b);
      end
      fr.push_back(($urandom_range(0, 3) == 0) ? (sum ^ 8'h01) : sum);
      send_frame(fr, k[0]);
      idle(3);
    end

    // Asynchronous reset mid-frame
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    fr = '{8'hA5, 8'h02, 8'h01, 8'h05, 8'h02};
    send_frame(fr, 0);
    #3 rst_n = 1'b0;
    #1;
    check_reset_vals("async");
    @(negedge clk);
    rst_n = 1'b1;
    send_frame(good, 0);
    idle(3);
    chk("after_rst_done", 32'(done), 32'd1);
    chk("after_rst_cnt", 32'(loaded_count), 32'd2);

    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
